iir_preemph: RTL and testbench
==============================

# iir_preemph

First-order IIR pre-emphasis filter with zero-stuffing interpolation, the transmit-side counterpart of the receive-chain de-emphasis filter. Reads signed Q10 samples from an upstream FWFT FIFO. Emits INTERP filtered outputs per input sample into a downstream FIFO. Output recurrence: y[n] = B0·x[n] + B1·x[n-1] − A1·y[n-1].

## Interface
- DATA_WIDTH, 32: sample width, signed two's complement, Q10 fixed point.
- INTERP, 1: outputs per input sample; must be ≥ 1. Inserts INTERP−1 zero samples after each real sample.
- B0, 2945: Q10 coefficient on x[n] (≈2.876).
- B1, -1915: Q10 coefficient on x[n-1] (≈−1.870).
- A1, 0: Q10 feedback coefficient on y[n-1].
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- x_in  in  DATA_WIDTH  input sample; valid whenever x_in_empty=0 (FWFT).
- x_in_rd_en  out  1  pops x_in this cycle.
- x_in_empty  in  1  upstream FIFO empty.
- y_out  out  DATA_WIDTH  output sample, registered.
- y_out_wr_en  out  1  pushes y_out this cycle.
- y_out_full  in  1  downstream FIFO full.

## Operation
- State machine: S_READ, S_COMPUTE, S_WRITE. Reset state is S_READ.
- Registers: x0 (current filter input), x1 (previous filter input), y1 (previous output), phase counter 0..INTERP−1, y_out.
- S_READ:
  - If x_in_empty=0: x_in_rd_en=1 (combinational), x0←x_in, phase←0, go to S_COMPUTE.
  - Otherwise stay in S_READ with rd_en=0.
- S_COMPUTE (one cycle): y_out ← sat(mul(x0,B0) + mul(x1,B1) − mul(y1,A1)). Go to S_WRITE.
- S_WRITE:
  - y_out_wr_en = (y_out_full=0), combinational.
  - On a write: x1←x0, y1←y_out.
  - After the write, if phase<INTERP−1: phase←phase+1, x0←0, go to S_COMPUTE.
  - After the write, if phase=INTERP−1: go to S_READ.
  - While full: hold all state; y_out stays stable.
- mul(a,c):
  - Full 2·DATA_WIDTH signed product p.
  - Dequantize with round toward zero: (p + (p<0 ? 1023 : 0)) >>> 10.
  - Result kept at 2·DATA_WIDTH bits; no truncation before the sum.
- Sum is taken at 2·DATA_WIDTH+2 bits. sat() clamps to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- History (x1, y1) advances on every output, zero-stuffed ones included.
- rd_en and wr_en are never high in the same cycle. There is no read in S_COMPUTE or S_WRITE.

## Timing
- Reset values: x_in_rd_en=0, y_out_wr_en=0, y_out=0, x0=x1=y1=0, phase=0, state S_READ.
- Reset mid-operation discards any pending output and clears all history. No write is issued for it.
- Latency: pop in cycle t → y_out valid and wr_en high in t+2 (downstream not full).
- Throughput:
  - Real sample: 3 cycles per output.
  - Zero-stuffed sample: 2 cycles per output.
  - One input consumes 2·INTERP+1 cycles minimum.
- Empty upstream: block idles in S_READ. No output is produced and history is unchanged.
- Full asserted in S_WRITE: wr_en=0 until full deasserts. Exactly one write per computed sample, never duplicated.
- Full deasserting and empty deasserting in the same cycle: the write completes first; the read occurs in the following S_READ cycle.

## Test plan
- Reset: assert reset mid-S_WRITE with full=1. Required: all outputs 0 within the same cycle. After release, first input 1024 → y_out=2945 (history cleared).
- Impulse, INTERP=1: inputs 1024, 0, 0, 0 → outputs 2945, −1915, 0, 0. Each wr_en fires exactly 2 cycles after its rd_en.
- Step, INTERP=1: constant 1024 ×4 → outputs 2945, 1030, 1030, 1030.
- Interpolation, INTERP=2: inputs 1024, 1024 → outputs 2945, −1915, 2945, −1915. Exactly 2 rd_en pulses and 4 wr_en pulses.
- Rounding and saturation:
  - Input −1 → output −2 (round toward zero).
  - Fresh reset, then input 2^30 → output 2147483647 (positive clamp).
  - Fresh reset, then input −2^30 → output −2147483648 (negative clamp).
- Backpressure: hold full=1 for 5 cycles in S_WRITE. Required: wr_en=0, y_out stable and rd_en=0 throughout. After release: one wr_en pulse, then normal reads resume with no sample lost.

Source files
------------

// File: rtl/iir_preemph.sv
// rtl/iir_preemph.sv - first-order Q10 IIR pre-emphasis filter with zero-stuffing interpolation
module iir_preemph #(
  parameter int DATA_WIDTH = 32,
  parameter int INTERP     = 1,
  parameter int B0         = 2945,
  parameter int B1         = -1915,
  parameter int A1         = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] x_in,
  output logic                  x_in_rd_en,
  input  logic                  x_in_empty,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic                  y_out_wr_en,
  input  logic                  y_out_full
);

  localparam int PW     = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = PROD_W + 2;

  localparam logic signed [DATA_WIDTH-1:0] B0_Q = DATA_WIDTH'(B0);
  localparam logic signed [DATA_WIDTH-1:0] B1_Q = DATA_WIDTH'(B1);
  localparam logic signed [DATA_WIDTH-1:0] A1_Q = DATA_WIDTH'(A1);
  localparam logic [PW-1:0]                LAST_PHASE = PW'(INTERP - 1);

  typedef enum logic [1:0] {
    S_READ,
    S_COMPUTE,
    S_WRITE
  } state_t;

  state_t                        state;
  logic signed [DATA_WIDTH-1:0]  x0;
  logic signed [DATA_WIDTH-1:0]  x1;
  logic signed [DATA_WIDTH-1:0]  y1;
  logic [PW-1:0]                 phase;
  logic signed [SUM_W-1:0]       acc;
  logic [DATA_WIDTH-1:0]         y_sat;

  // Q10 product, rounded toward zero, kept at full double width.
  function automatic logic signed [PROD_W-1:0] mul_q10(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] c
  );
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(c);
    if (p < 0) begin
      p = p + PROD_W'(1023);
    end
    return p >>> 10;
  endfunction

  always_comb begin
    acc = SUM_W'(mul_q10(x0, B0_Q)) + SUM_W'(mul_q10(x1, B1_Q)) - SUM_W'(mul_q10(y1, A1_Q));
    if (acc[SUM_W-1:DATA_WIDTH-1] == {(SUM_W-DATA_WIDTH+1){acc[SUM_W-1]}}) begin
      y_sat = acc[DATA_WIDTH-1:0];
    end else if (acc[SUM_W-1]) begin
      y_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      y_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  // Handshakes are gated by reset so both strobes are low while reset is held.
  assign x_in_rd_en  = !reset && (state == S_READ)  && !x_in_empty;
  assign y_out_wr_en = !reset && (state == S_WRITE) && !y_out_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_READ;
      x0    <= '0;
      x1    <= '0;
      y1    <= '0;
      phase <= '0;
      y_out <= '0;
    end else begin
      case (state)
        S_READ: begin
          if (!x_in_empty) begin
            x0    <= $signed(x_in);
            phase <= '0;
            state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          y_out <= y_sat;
          state <= S_WRITE;
        end
        S_WRITE: begin
          if (!y_out_full) begin
            x1 <= x0;
            y1 <= $signed(y_out);
            if (phase != LAST_PHASE) begin
              phase <= phase + PW'(1);
              x0    <= '0;
              state <= S_COMPUTE;
            end else begin
              state <= S_READ;
            end
          end
        end
        default: state <= S_READ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_preemph.sv
// tb/tb_iir_preemph.sv - directed self-checking bench for iir_preemph
module tb_iir_preemph;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] a_x, b_x;
  logic        a_empty, b_empty, a_full, b_full;
  logic        a_rd, b_rd, a_wr, b_wr;
  logic [31:0] a_y, b_y;
  int          checks = 0;
  int          errors = 0;
  int          b_rd_cnt = 0;
  int          b_wr_cnt = 0;

  always #5 clock = ~clock;

  iir_preemph #(.DATA_WIDTH(32), .INTERP(1)) dut_a (
    .clock(clock), .reset(reset),
    .x_in(a_x), .x_in_rd_en(a_rd), .x_in_empty(a_empty),
    .y_out(a_y), .y_out_wr_en(a_wr), .y_out_full(a_full)
  );

  iir_preemph #(.DATA_WIDTH(32), .INTERP(2)) dut_b (
    .clock(clock), .reset(reset),
    .x_in(b_x), .x_in_rd_en(b_rd), .x_in_empty(b_empty),
    .y_out(b_y), .y_out_wr_en(b_wr), .y_out_full(b_full)
  );

  always @(posedge clock) begin
    if (b_rd) b_rd_cnt <= b_rd_cnt + 1;
    if (b_wr) b_wr_cnt <= b_wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  // One input through the INTERP=1 instance; hold = cycles of downstream full in S_WRITE.
  task automatic send_a(input logic [31:0] v, input logic [31:0] exp, input int hold, input string tag);
    a_x = v; a_empty = 1'b0;
    #1;
    chk({tag, "_rd"}, a_rd, 1);
    chk({tag, "_nodup"}, a_wr, 0);
    @(posedge clock); #1 a_empty = 1'b1;
    #1;
    chk({tag, "_comp"}, {a_rd, a_wr}, 0);
    @(posedge clock); #1;
    if (hold > 0) begin
      a_full = 1'b1; a_empty = 1'b0; a_x = 32'h0000_1234;
    end
    for (int i = 0; i < hold; i++) begin
      #1;
      chk({tag, "_bp_wr"}, a_wr, 0);
      chk({tag, "_bp_rd"}, a_rd, 0);
      chk({tag, "_bp_y"}, a_y, exp);
      @(posedge clock); #1;
    end
    a_full = 1'b0; a_empty = 1'b1;
    #1;
    chk({tag, "_wr"}, a_wr, 1);
    chk({tag, "_y"}, a_y, exp);
    @(posedge clock); #1;
  endtask

  task automatic send_b(input logic [31:0] v, input logic [31:0] e0, input logic [31:0] e1, input string tag);
    b_x = v; b_empty = 1'b0;
    #1;
    chk({tag, "_rd"}, b_rd, 1);
    @(posedge clock); #1 b_empty = 1'b1;
    #1;
    chk({tag, "_comp0"}, {b_rd, b_wr}, 0);
    @(posedge clock); #1;
    chk({tag, "_wr0"}, b_wr, 1);
    chk({tag, "_y0"}, b_y, e0);
    @(posedge clock); #1;
    chk({tag, "_comp1"}, {b_rd, b_wr}, 0);
    @(posedge clock); #1;
    chk({tag, "_wr1"}, b_wr, 1);
    chk({tag, "_y1"}, b_y, e1);
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1;
    a_x = 32'd7; a_empty = 1'b0; a_full = 1'b0;
    b_x = 32'd0; b_empty = 1'b1; b_full = 1'b0;
    #2;
    chk("reset_rd", a_rd, 0);
    chk("reset_wr", a_wr, 0);
    chk("reset_y", a_y, 0);
    chk("reset_b_y", b_y, 0);
    a_empty = 1'b1;
    @(posedge clock); #1 reset = 1'b0;

    // Reset asserted mid-S_WRITE while downstream is full.
    send_a(32'd1024, 32'd2945, 0, "rst_pre");
    a_x = 32'd5000; a_empty = 1'b0;
    #1;
    chk("rst_mid_rd", a_rd, 1);
    @(posedge clock); #1 a_empty = 1'b1; a_full = 1'b1;
    @(posedge clock); #1;
    chk("rst_mid_wr_full", a_wr, 0);
    chk("rst_mid_y", a_y, 32'd12464);
    reset = 1'b1; a_empty = 1'b0;
    #1;
    chk("rst_async_y", a_y, 0);
    chk("rst_async_wr", a_wr, 0);
    chk("rst_async_rd", a_rd, 0);
    @(posedge clock); #1 reset = 1'b0; a_full = 1'b0; a_empty = 1'b1;
    #1;
    chk("rst_no_write", a_wr, 0);
    send_a(32'd1024, 32'd2945, 0, "rst_post");

    do_reset();
    send_a(32'd1024, 32'd2945, 0, "imp0");
    send_a(32'd0, -32'sd1915, 0, "imp1");
    send_a(32'd0, 32'd0, 0, "imp2");
    send_a(32'd0, 32'd0, 0, "imp3");

    do_reset();
    send_a(32'd1024, 32'd2945, 0, "step0");
    send_a(32'd1024, 32'd1030, 0, "step1");
    send_a(32'd1024, 32'd1030, 0, "step2");
    send_a(32'd1024, 32'd1030, 0, "step3");

    do_reset();
    send_a(32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "round_neg1");
    do_reset();
    send_a(32'h4000_0000, 32'h7FFF_FFFF, 0, "sat_pos");
    do_reset();
    send_a(32'hC000_0000, 32'h8000_0000, 0, "sat_neg");

    do_reset();
    send_a(32'd1024, 32'd2945, 5, "bp");
    send_a(32'd2048, 32'd3975, 0, "bp_next");

    send_b(32'd1024, 32'd2945, -32'sd1915, "interp0");
    send_b(32'd1024, 32'd2945, -32'sd1915, "interp1");
    @(posedge clock); #1;
    chk("interp_rd_count", b_rd_cnt, 2);
    chk("interp_wr_count", b_wr_cnt, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
